req_arbiter: RTL and testbench

//   Sequential arbiter that shares one downstream resource among N_REQ requesters.

---
 rtl/arb_pkg.sv | 18 +
 rtl/arb_prio_enc.sv | 53 +++++
 rtl/req_arbiter.sv | 131 +++++++++++++
 tb/tb_req_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and defaults for the request arbiter
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int N_REQ_DEF    = 4;
    localparam int ID_W_DEF     = 2;
    localparam int MAX_HOLD_DEF = 16;

    // MAX_HOLD=0 (unlimited) still needs a 1-bit counter so the port widths stay legal
    function automatic int hold_w(input int max_hold);
        return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/arb_prio_enc.sv
// rtl/arb_prio_enc.sv - 4->2 priority encoder; rotates its search by last_id under ARB_ROUND_ROBIN_EN
module arb_prio_enc
    import arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic [N_REQ-1:0] req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic [ID_W-1:0]  last_id,
`endif
    output logic [ID_W-1:0]  win_id,
    output logic             win_valid
);

    logic [N_REQ-1:0] rot;
    logic [ID_W-1:0]  rot_id;
`ifdef ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0]  src_idx;
`endif

    // Rotation maps requester last_id-1 onto bit N_REQ-1, so the fixed top-down
    // search below walks last_id-1, last_id-2, ... and wraps around.
    always_comb begin
        rot = '0;
`ifdef ARB_ROUND_ROBIN_EN
        src_idx = '0;
        for (int j = 0; j < N_REQ; j++) begin
            src_idx = ID_W'(j) + last_id;
            rot[j]  = req[src_idx];
        end
`else
        rot = req;
`endif
    end

    always_comb begin
        rot_id    = '0;
        win_valid = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (rot[j]) begin
                rot_id    = ID_W'(j);
                win_valid = 1'b1;
            end
        end
`ifdef ARB_ROUND_ROBIN_EN
        win_id = rot_id + last_id;
`else
        win_id = rot_id;
`endif
    end

endmodule

// File: rtl/req_arbiter.sv
// rtl/req_arbiter.sv - IDLE/BUSY arbiter with registered one-hot grant and hold timeout
// Optional rotating priority via ARB_ROUND_ROBIN_EN.
module req_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int ID_W     = ID_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_valid,
    output logic             preempt
);

    localparam int              HOLD_W     = hold_w(MAX_HOLD);
    localparam bit              TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = TIMEOUT_EN ? HOLD_W'(MAX_HOLD - 1) : '0;
    localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              grant_valid_q, grant_valid_d;
    logic              preempt_q, preempt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0]   last_id_q, last_id_d;
`endif

    logic [ID_W-1:0]   enc_id;
    logic              enc_valid;
    logic              owner_req;
    logic              others_req;
    logic              hold_expired;

    arb_prio_enc #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_enc (
        .req       (req),
`ifdef ARB_ROUND_ROBIN_EN
        .last_id   (last_id_q),
`endif
        .win_id    (enc_id),
        .win_valid (enc_valid)
    );

    always_comb begin
        owner_req    = req[grant_id_q];
        others_req   = |(req & ~grant_q);
        hold_expired = TIMEOUT_EN && (hold_cnt_q == HOLD_LAST);

        state_d       = state_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        preempt_d     = 1'b0;
        hold_cnt_d    = hold_cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_id_d     = last_id_q;
`endif

        case (state_q)
            IDLE: begin
                grant_d       = '0;
                grant_id_d    = '0;
                grant_valid_d = 1'b0;
                hold_cnt_d    = '0;
                if (enc_valid) begin
                    state_d       = BUSY;
                    grant_d       = N_REQ'(1) << enc_id;
                    grant_id_d    = enc_id;
                    grant_valid_d = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    last_id_d     = enc_id;
`endif
                end
            end
            BUSY: begin
                // Release wins over a simultaneous timeout, so it is tested first.
                if (!owner_req || (hold_expired && others_req)) begin
                    state_d       = IDLE;
                    grant_d       = '0;
                    grant_id_d    = '0;
                    grant_valid_d = 1'b0;
                    hold_cnt_d    = '0;
                    preempt_d     = owner_req;
                end else if (hold_expired) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            preempt_q     <= 1'b0;
            hold_cnt_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_id_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            preempt_q     <= preempt_d;
            hold_cnt_q    <= hold_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_id_q     <= last_id_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;
    assign preempt     = preempt_q;

endmodule

// File: tb/tb_req_arbiter.sv
// tb/tb_req_arbiter.sv - vector table plus hand sequences for req_arbiter (MAX_HOLD=4)
module tb_req_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic       preempt;

    always #5 clk = ~clk;

    req_arbiter #(
        .N_REQ    (4),
        .ID_W     (2),
        .MAX_HOLD (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .preempt     (preempt)
    );

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] id;
        logic       v;
        logic       p;
    } exp_t;

    typedef struct packed {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] g;
        logic [1:0] id;
        logic       v;
        logic       p;
    } vec_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 8'd1, 8'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".grant"},       {4'b0, grant},       {4'b0, e.g});
            check({tag, ".grant_id"},    {6'b0, grant_id},    {6'b0, e.id});
            check({tag, ".grant_valid"}, {7'b0, grant_valid}, {7'b0, e.v});
            check({tag, ".preempt"},     {7'b0, preempt},     {7'b0, e.p});
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] g,
                        input logic [1:0] id, input logic v, input logic p, input string tag);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        req   = rq;
        e = '{g: g, id: id, v: v, p: p};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    vec_t vecs[11];

    initial begin
        // reset with all requests, then fixed-priority handover
        vecs[0]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 4'b0110, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 4'b0110, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].rst_n, vecs[i].req, vecs[i].g, vecs[i].id, vecs[i].v, vecs[i].p,
                 $sformatf("vec%0d", i));
        end

        // sole requester: timeout rolls the counter over, no preempt
        for (int i = 0; i < 21; i++) begin
            step(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, $sformatf("solo%0d", i));
        end
        step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "solo_rel");

        // timeout with a competing requester
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "to_rst");
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0, $sformatf("to_hold%0d", i));
        end
        step(1'b1, 4'b1001, 4'b0000, 2'd0, 1'b0, 1'b1, "to_preempt");
`ifdef ARB_ROUND_ROBIN_EN
        step(1'b1, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0, "to_regrant");
        step(1'b1, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0, "to_regrant_hold");
`else
        step(1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0, "to_regrant");
        step(1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0, "to_regrant_hold");
`endif
        step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "to_rel");

        // release and timeout in the same cycle
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "both_rst");
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0, $sformatf("both_hold%0d", i));
        end
        step(1'b1, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0, "both_release");
        step(1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, "both_regrant");

        // asynchronous reset while BUSY
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst.grant",       {4'b0, grant},       8'h00);
        check("async_rst.grant_valid", {7'b0, grant_valid}, 8'h00);
        check("async_rst.grant_id",    {6'b0, grant_id},    8'h00);
        @(posedge clk);
        #1;
        check("async_rst.preempt",     {7'b0, preempt},     8'h00);

        check("sb_leftover", 8'(sb_q.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
